// File: rtl/reg_mux_n_if.sv
// Channel data, select handshake and registered output of reg_mux_n.
interface reg_mux_n_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
);
  logic [CHANNELS*WIDTH-1:0] in;
  logic                      sel_req;
  logic [SEL_W-1:0]          sel;
  logic                      sel_ack;
  logic                      sel_err;
  logic                      busy;
  logic [SEL_W-1:0]          cur;
  logic [WIDTH-1:0]          out;
  logic                      out_valid;

  modport master (
    output in, sel_req, sel,
    input  sel_ack, sel_err, busy, cur, out, out_valid
  );

  modport slave (
    input  in, sel_req, sel,
    output sel_ack, sel_err, busy, cur, out, out_valid
  );
endinterface

// File: rtl/reg_mux_n.sv
// Registered N:1 bus multiplexer; each channel change blanks the output for SETTLE cycles.
module reg_mux_n #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int SETTLE   = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  reg_mux_n_if.slave    bus
);
  localparam int CNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [SEL_W:0] CH_LIM = (SEL_W + 1)'(CHANNELS);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE - 1);

  localparam logic [0:0] ST_PASS  = 1'b0;
  localparam logic [0:0] ST_BLANK = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] pending;
  logic [SEL_W-1:0] cur;
  logic [WIDTH-1:0] out_q;
  logic             out_valid;
  logic             sel_ack;
  logic             sel_err;
  logic             busy;

  logic [WIDTH-1:0] cur_data;
  logic [WIDTH-1:0] pend_data;
  logic             sel_ok;
  logic             do_switch;

  // Explicit per-channel compare keeps non-power-of-two CHANNELS free of out-of-range indexing.
  always_comb begin
    cur_data  = '0;
    pend_data = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (cur == SEL_W'(i))     cur_data  = bus.in[i*WIDTH +: WIDTH];
      if (pending == SEL_W'(i)) pend_data = bus.in[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    sel_ok    = ({1'b0, bus.sel} < CH_LIM);
    do_switch = bus.sel_req && sel_ok && (bus.sel != cur);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_PASS;
      cur       <= '0;
      pending   <= '0;
      cnt       <= '0;
      out_q     <= '0;
      out_valid <= 1'b0;
      sel_ack   <= 1'b0;
      sel_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      sel_ack <= 1'b0;
      sel_err <= 1'b0;
      case (state)
        ST_PASS: begin
          if (do_switch) begin
            state     <= ST_BLANK;
            pending   <= bus.sel;
            cnt       <= CNT_INIT;
            out_valid <= 1'b0;
            busy      <= 1'b1;
          end else begin
            out_q     <= cur_data;
            out_valid <= 1'b1;
            if (bus.sel_req) begin
              if (!sel_ok) sel_err <= 1'b1;
              else         sel_ack <= 1'b1;
            end
          end
        end
        default: begin
          // Requests are dropped here; out_q holds the old channel until the switch lands.
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state     <= ST_PASS;
            cur       <= pending;
            out_q     <= pend_data;
            out_valid <= 1'b1;
            sel_ack   <= 1'b1;
            busy      <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.sel_ack   = sel_ack;
  assign bus.sel_err   = sel_err;
  assign bus.busy      = busy;
  assign bus.cur       = cur;
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid;
endmodule

// File: doc/reg_mux_n.md
# reg_mux_n

Parametrised, registered N:1 multiplexer for WIDTH-bit buses. It generalises our gate-level 2:1 selector to CHANNELS inputs with a registered output and a select request/acknowledge handshake. Every channel change blanks the output for a fixed settle interval, so downstream registers never capture mixed-channel data. It sits between the register-file read ports and any consumer that needs a glitch-free, clock-aligned source select.

## Interface
- WIDTH, 8: data width per channel, ≥1.
- CHANNELS, 4: number of input channels, ≥2.
- SEL_W, 2: select width, ≥ceil(log2(CHANNELS)).
- SETTLE, 2: blanking length in clock cycles on a channel change, ≥1.

- CLK  input  1  single clock; all state changes on the rising edge.
- RST_N  input  1  reset, asynchronous and active-low.
- IN  input  CHANNELS*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- SEL_REQ  input  1  select-change request, sampled at the rising edge.
- SEL  input  SEL_W  requested channel, qualified by SEL_REQ.
- SEL_ACK  output  1  one-cycle pulse: request completed.
- SEL_ERR  output  1  one-cycle pulse: request rejected because SEL ≥ CHANNELS.
- BUSY  output  1  high while blanking; requests are ignored.
- CUR  output  SEL_W  currently active channel.
- OUT  output  WIDTH  registered selected data.
- OUT_VALID  output  1  OUT holds data from CUR captured on the last edge.

## Operation
- States: PASS and BLANK. Internal registers: cnt (ceil(log2(SETTLE+1)) bits) and pending (SEL_W bits).
- Reset (RST_N=0, asynchronous): state=PASS, CUR=0, pending=0, cnt=0, OUT=0, OUT_VALID=0, SEL_ACK=0, SEL_ERR=0, BUSY=0.
- PASS, per edge: OUT<=IN[CUR] and OUT_VALID<=1. SEL_ACK and SEL_ERR default to 0 unless set below.
- PASS with SEL_REQ=1:
  - SEL ≥ CHANNELS: SEL_ERR<=1. CUR is unchanged and the normal OUT update still happens.
  - SEL == CUR: SEL_ACK<=1. No blanking; the normal OUT update happens.
  - Otherwise (valid, different channel): state<=BLANK, pending<=SEL, cnt<=SETTLE-1, OUT holds, OUT_VALID<=0, BUSY<=1.
- BLANK, per edge: OUT holds and OUT_VALID stays 0.
  - cnt ≠ 0: cnt<=cnt-1.
  - cnt == 0: CUR<=pending, OUT<=IN[pending], OUT_VALID<=1, SEL_ACK<=1, BUSY<=0, state<=PASS.
- SEL_REQ during BLANK is ignored: no ACK, no ERR, and no queuing. The requester must wait for BUSY=0.
- The SEL_ACK pulse and acceptance of a new request can coincide on the first PASS edge. A request sampled on that edge is evaluated normally.
- Reset asserted mid-BLANK aborts the switch: CUR returns to 0 and the pending selection is discarded.

## Timing
- Data latency in PASS is 1 cycle: IN[CUR] sampled at edge k appears on OUT after edge k.
- A switch request accepted at edge k produces:
  - OUT_VALID=0 and BUSY=1 from edge k through edge k+SETTLE-1;
  - new-channel data, SEL_ACK=1 and CUR updated after edge k+SETTLE.
- OUT_VALID is therefore low for exactly SETTLE cycles per switch.
- Same-channel and error responses occur 1 cycle after the request edge, with no blanking.
- After reset release, OUT_VALID rises at the first rising edge, with OUT=IN[0].
- All outputs are registered. There are no combinational paths from IN, SEL or SEL_REQ to any output.

## Test plan
- Reset and pass-through: WIDTH=8, CHANNELS=4, SETTLE=2. Set IN ch0=0x11, ch1=0x22, ch2=0x33, ch3=0x44. Assert reset, then release. Required: OUT=0x00 and OUT_VALID=0 during reset; OUT=0x11, OUT_VALID=1 and CUR=0 after the first edge.
- Switch: pulse SEL_REQ with SEL=2 at edge k. Required: OUT holds 0x11 with OUT_VALID=0 and BUSY=1 for 2 cycles. After edge k+2: OUT=0x33, CUR=2, and SEL_ACK is a single-cycle pulse.
- Same channel and error:
  - SEL_REQ with SEL=2 while CUR=2: SEL_ACK pulses the next cycle and OUT_VALID never drops.
  - Rebuild with CHANNELS=3 and send SEL=3: SEL_ERR pulses, CUR and OUT are unchanged.
- Request during BLANK: with SETTLE=4, request SEL=1, then request SEL=3 two cycles later. Required: only one SEL_ACK; the final state is CUR=1, OUT=0x22.
- Back-to-back: request SEL=3 on the same edge that SEL_ACK for SEL=1 is high. Required: a new BLANK begins and ends with CUR=3, OUT=0x44.
- Reset mid-BLANK: assert RST_N=0 asynchronously, between edges, during BLANK. Required: immediately OUT=0, CUR=0, BUSY=0. After release: OUT=0x11 and no SEL_ACK is emitted.
